// File: rtl/winograd_input_xform_stream_if.sv
// Row-beat stream bundle for the Winograd F(2x2,3x3) input transform:
// input tile rows in, transformed rows out, each with its own valid/ready.
interface winograd_input_xform_stream_if #(
  parameter int WIDTH = 16,
  parameter int CH    = 1,
  parameter int OUT_W = WIDTH + 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CH*4*WIDTH-1:0]    in_data;
  logic                     in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH*4*OUT_W-1:0]    out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/winograd_input_xform_stream.sv
// Streaming Winograd input transform I = B_T*d*B over 4x4 tiles, per channel,
// with ping-pong tile buffers and a registered output row stage.
module winograd_input_xform_stream #(
  parameter int WIDTH = 16,
  parameter int CH    = 1,
  parameter int OUT_W = WIDTH + 2
) (
  input  logic clk,
  input  logic rst,
  winograd_input_xform_stream_if.slave bus
);
  localparam int NE = CH * 4;

  typedef enum logic [1:0] {FREE, FILLING, FULL, EMITTING} buf_st_t;

  buf_st_t                 st      [2];
  logic signed [WIDTH-1:0] mem     [2][4][NE];
  logic                    mode_q  [2];
  logic                    wr_sel, rd_sel;
  logic [1:0]              wr_row, rd_row;

  logic                    fire_in, fire_out, cand, cand_ok, load, nx_buf;
  logic [1:0]              nx_row;
  logic [NE*OUT_W-1:0]     nx_data;
  logic signed [OUT_W-1:0] dv [4][4];
  logic signed [OUT_W-1:0] xv [4];
  logic signed [OUT_W-1:0] yv [4];

  assign bus.in_ready = !(((st[0] == FULL) || (st[0] == EMITTING)) &&
                          ((st[1] == FULL) || (st[1] == EMITTING)));

  // Output row 0 only needs tile rows 0 and 2, so a tile whose row 3 is being
  // accepted this cycle can already launch its first output row.
  always_comb begin
    fire_in  = bus.in_valid && bus.in_ready;
    fire_out = bus.out_valid && bus.out_ready;
    cand     = (fire_out && bus.out_last) ? ~rd_sel : rd_sel;
    cand_ok  = (st[cand] == FULL) ||
               ((st[cand] == FILLING) && (wr_sel == cand) && fire_in && (wr_row == 2'd3));
    nx_buf   = rd_sel;
    nx_row   = rd_row + 2'd1;
    load     = 1'b0;
    if (fire_out && !bus.out_last) begin
      load = 1'b1;
    end else if (fire_out || !bus.out_valid) begin
      nx_buf = cand;
      nx_row = '0;
      load   = cand_ok;
    end
  end

  always_comb begin
    nx_data = '0;
    dv      = '{default: '0};
    xv      = '{default: '0};
    yv      = '{default: '0};
    for (int unsigned c = 0; c < CH; c++) begin
      for (int unsigned r = 0; r < 4; r++)
        for (int unsigned j = 0; j < 4; j++)
          dv[r][j] = OUT_W'(mem[nx_buf][r][c*4+j]);
      for (int unsigned j = 0; j < 4; j++) begin
        if (mode_q[nx_buf]) begin
          xv[j] = dv[nx_row][j];
        end else begin
          case (nx_row)
            2'd0:    xv[j] = dv[0][j] - dv[2][j];
            2'd1:    xv[j] = dv[1][j] + dv[2][j];
            2'd2:    xv[j] = dv[2][j] - dv[1][j];
            default: xv[j] = dv[1][j] - dv[3][j];
          endcase
        end
      end
      if (mode_q[nx_buf]) begin
        yv = xv;
      end else begin
        yv[0] = xv[0] - xv[2];
        yv[1] = xv[1] + xv[2];
        yv[2] = xv[2] - xv[1];
        yv[3] = xv[1] - xv[3];
      end
      for (int unsigned j = 0; j < 4; j++)
        nx_data[(c*4+j)*OUT_W +: OUT_W] = yv[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]         <= FREE;
      st[1]         <= FREE;
      wr_sel        <= '0;
      rd_sel        <= '0;
      wr_row        <= '0;
      rd_row        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (fire_in) begin
        for (int unsigned e = 0; e < NE; e++)
          mem[wr_sel][wr_row][e] <= bus.in_data[e*WIDTH +: WIDTH];
        if (wr_row == 2'd0) begin
          mode_q[wr_sel] <= bus.in_mode;
          st[wr_sel]     <= FILLING;
        end
        if (wr_row == 2'd3) begin
          st[wr_sel] <= FULL;
          wr_sel     <= ~wr_sel;
        end
        wr_row <= wr_row + 2'd1;
      end
      if (fire_out && bus.out_last)
        st[rd_sel] <= FREE;
      // Emit updates come last so a same-cycle FULL from the fill path is
      // promoted straight to EMITTING.
      if (fire_out || !bus.out_valid) begin
        bus.out_valid <= load;
        bus.out_last  <= load && (nx_row == 2'd3);
        rd_sel        <= nx_buf;
        if (load) begin
          bus.out_data <= nx_data;
          rd_row       <= nx_row;
          if (nx_row == 2'd0)
            st[nx_buf] <= EMITTING;
        end
      end
    end
  end
endmodule
